fir_rrc_sched: RTL and testbench
================================

Name: fir_rrc_sched

Overview:
Symbol scheduler and sequencer for the fir_rrc pulse-shaping filter. It accepts signed 12-bit symbols over a valid/ready handshake and upsamples them by zero-stuffing to SAMPLES_PER_SYMBOL samples per symbol, one sample per clock. At end of burst it drives NUM_TAPS-1 zero samples to flush the filter tail. It sits between the modulator's symbol mapper and fir_rrc. It also produces a valid strobe aligned with the filter output.

Parameters:
SAMPLES_PER_SYMBOL, 4, upsampling factor; legal values 1..16.
NUM_TAPS, 21, fir_rrc tap count; the flush length is NUM_TAPS-1.
FIR_LATENCY, 1, clocks from a fir_in change to the matching fir_rrc out change; legal values 1..8.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
symbol_in  in  12  signed symbol value
symbol_valid  in  1  symbol_in and symbol_last are valid
symbol_last  in  1  marks the final symbol of a burst
symbol_ready  out  1  block accepts a symbol this cycle
fir_in  out  12  sample to fir_rrc.in (registered)
fir_in_valid  out  1  fir_in carries a burst sample
fir_out_valid  out  1  fir_in_valid delayed by FIR_LATENCY; qualifies fir_rrc.out
busy  out  1  state is not IDLE
underflow  out  1  one-cycle pulse when a zero is substituted for a missing symbol
done  out  1  one-cycle pulse on the last flush sample
underflow_count  out  16  see Optional Feature

Behaviour:
- Reset values. On a clock edge with rst high, all outputs go to 0 except symbol_ready, which goes to 1 (IDLE). This includes fir_in, the valids, the fir_out_valid delay line, the counters and the FSM state. Reset mid-burst aborts the burst immediately; no flush is performed.
- Transfer rule. A transfer occurs when symbol_valid and symbol_ready are both high at the clock edge. The transferred symbol appears on fir_in on the next cycle.
- States: IDLE, RUN, FLUSH. Phase counter ph runs 0..SPS-1.
- IDLE:
  - symbol_ready=1, fir_in=0, fir_in_valid=0.
  - On transfer: go to RUN, set ph=0, fir_in=symbol_in, and latch last=symbol_last.
- RUN:
  - fir_in_valid=1. fir_in equals the symbol when ph=0, otherwise 0.
  - ph increments each cycle and wraps SPS-1 -> 0.
  - symbol_ready = (ph==SPS-1) and not last. When SPS=1 this means every cycle until last.
  - At ph==SPS-1 with the latched last=1: go to FLUSH.
  - At ph==SPS-1 with ready high but no transfer: substitute a 0 symbol at the next ph=0 and pulse underflow on that cycle. The FSM stays in RUN; symbol continuity is preserved.
- FLUSH:
  - symbol_ready=0, fir_in=0, fir_in_valid=1 for exactly NUM_TAPS-1 cycles.
  - done pulses on the last of those cycles, then the FSM goes to IDLE.
  - A symbol_valid presented during FLUSH is held off and accepted in IDLE. The earliest IDLE transfer starts the next burst with no gap cycle beyond the IDLE cycle.
- busy is 1 in RUN and FLUSH.
- fir_in is passed through unmodified; there is no arithmetic on it.
- fir_out_valid is a FIR_LATENCY-deep shift of fir_in_valid.
- Burst length. A burst of N symbols gives fir_in_valid high for N*SPS + NUM_TAPS-1 consecutive cycles.

Optional Feature:
Macro: FIR_RRC_SCHED_UNDERFLOW_COUNT_EN.
- Defined: underflow_count is a 16-bit counter that increments on each underflow pulse. It saturates at 16'hFFFF, clears on rst, and is not cleared between bursts.
- Undefined: no counter logic is built and underflow_count is tied to 16'h0000.

Test Plan:
- Reset hold: rst held high for 50 cycles with symbol_valid=1 -> fir_in=0, all valids=0, symbol_ready=1, and no transfer occurs.
- Single-symbol burst, SPS=4: symbol_in=12'h7FF with last=1 -> fir_in sequence 7FF,0,0,0 followed by 20 zeros; fir_in_valid high for 24 cycles; done pulses on cycle 24; fir_out_valid rises 1 cycle after fir_in_valid; with fir_rrc attached, out follows the impulse response -8,7,21,...,581,...,-8 at 4x spacing.
- Back-to-back burst: symbols 100,-100,50 presented continuously, last on the third -> symbol_ready high only at ph=3; fir_in=100,0,0,0,-100,0,0,0,50,0,0,0 then 20 zeros; underflow never pulses.
- Underflow: symbol_valid dropped for one symbol slot mid-burst -> that slot's ph=0 sample is 0 and underflow pulses once; with the macro defined, underflow_count=1.
- SPS=1 corner: 5 consecutive symbols with last on the fifth -> ready every cycle, fir_in_valid for 25 cycles, and no zero-stuffing.
- Reset mid-FLUSH: rst asserted on flush cycle 10 -> next cycle IDLE, fir_in=0, fir_out_valid cleared, and no done pulse.

Source files
------------

// File: rtl/fir_rrc_sched.sv
// fir_rrc_sched -- symbol scheduler / sequencer in front of the fir_rrc
// pulse-shaping filter.
//
// Accepts signed 12-bit symbols on a valid/ready handshake and zero-stuffs
// each one to SAMPLES_PER_SYMBOL samples, one sample per clock. After the
// symbol flagged last has been played out, NUM_TAPS-1 zero samples flush the
// filter tail. A symbol slot with no symbol available is filled with zero and
// flagged on underflow. fir_out_valid is fir_in_valid delayed by FIR_LATENCY.
//
// Optional build macro: FIR_RRC_SCHED_UNDERFLOW_COUNT_EN
//   defined   -> underflow_count is a saturating 16-bit count of underflows
//   undefined -> underflow_count is tied to zero
//
// Ports:
//   clk              system clock
//   rst              synchronous, active-high reset
//   symbol_in[11:0]  signed symbol
//   symbol_valid     symbol_in / symbol_last valid
//   symbol_last      final symbol of a burst
//   symbol_ready     a symbol is accepted this cycle when valid is high
//   fir_in[11:0]     registered sample to fir_rrc
//   fir_in_valid     fir_in carries a burst sample
//   fir_out_valid    qualifies fir_rrc output
//   busy             burst in progress (RUN or FLUSH)
//   underflow        one-cycle pulse on a zero-substituted symbol slot
//   done             one-cycle pulse on the last flush sample
//   underflow_count  underflow counter (see macro above)
module fir_rrc_sched #(
  parameter int SAMPLES_PER_SYMBOL = 4,
  parameter int NUM_TAPS           = 21,
  parameter int FIR_LATENCY        = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] symbol_in,
  input  logic        symbol_valid,
  input  logic        symbol_last,
  output logic        symbol_ready,
  output logic [11:0] fir_in,
  output logic        fir_in_valid,
  output logic        fir_out_valid,
  output logic        busy,
  output logic        underflow,
  output logic        done,
  output logic [15:0] underflow_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FLUSH = 2'b10
  } state_t;

  localparam logic [4:0]  PH_LAST = 5'(SAMPLES_PER_SYMBOL - 1);
  localparam logic [15:0] FL_LAST = 16'(NUM_TAPS - 2);

  state_t      state_r, state_s;
  logic [4:0]  ph_r, ph_s;
  logic        last_r, last_s;
  logic [15:0] fcnt_r, fcnt_s;
  logic [11:0] fir_in_r, fir_in_s;
  logic        fir_in_valid_r, fir_in_valid_s;
  logic        ready_r, ready_s;
  logic        busy_r, busy_s;
  logic        underflow_r, underflow_s;
  logic        done_r, done_s;
  logic        xfer_s;
  logic [FIR_LATENCY-1:0] dly_r;

  // Next-state and next-output decode; every output is computed for the
  // cycle after the coming edge so that all ports come straight off flops.
  always_comb begin
    state_s     = state_r;
    ph_s        = ph_r;
    last_s      = last_r;
    fcnt_s      = fcnt_r;
    fir_in_s    = 12'h000;
    underflow_s = 1'b0;
    xfer_s      = symbol_valid & ready_r;
    case (state_r)
      IDLE: begin
        if (xfer_s) begin
          state_s  = RUN;
          ph_s     = 5'd0;
          last_s   = symbol_last;
          fir_in_s = symbol_in;
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
        if (ph_r == PH_LAST) begin
          ph_s = 5'd0;
          if (last_r) begin
            state_s = FLUSH;
            fcnt_s  = 16'd0;
          end else if (xfer_s) begin
            fir_in_s = symbol_in;
            last_s   = symbol_last;
          end else begin
            // Missing symbol: keep the symbol grid, play a zero instead.
            underflow_s = 1'b1;
          end
        end else begin
          ph_s = ph_r + 5'd1;
        end
      end
      FLUSH: begin
        if (fcnt_r == FL_LAST) begin
          state_s = IDLE;
        end else begin
          fcnt_s = fcnt_r + 16'd1;
        end
      end
      default: begin
        state_s = IDLE;
        ph_s    = 5'd0;
        last_s  = 1'b0;
        fcnt_s  = 16'd0;
      end
    endcase
    fir_in_valid_s = (state_s != IDLE);
    busy_s         = (state_s != IDLE);
    done_s         = (state_s == FLUSH) && (fcnt_s == FL_LAST);
    ready_s        = (state_s == IDLE) ||
                     ((state_s == RUN) && (ph_s == PH_LAST) && !last_s);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      ph_r           <= 5'd0;
      last_r         <= 1'b0;
      fcnt_r         <= 16'd0;
      fir_in_r       <= 12'h000;
      fir_in_valid_r <= 1'b0;
      ready_r        <= 1'b1;
      busy_r         <= 1'b0;
      underflow_r    <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      ph_r           <= ph_s;
      last_r         <= last_s;
      fcnt_r         <= fcnt_s;
      fir_in_r       <= fir_in_s;
      fir_in_valid_r <= fir_in_valid_s;
      ready_r        <= ready_s;
      busy_r         <= busy_s;
      underflow_r    <= underflow_s;
      done_r         <= done_s;
    end
  end

  // fir_in_valid delay line matching the filter pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      dly_r <= {FIR_LATENCY{1'b0}};
    end else begin
      dly_r[0] <= fir_in_valid_r;
      for (int i = 1; i < FIR_LATENCY; i++) begin
        dly_r[i] <= dly_r[i-1];
      end
    end
  end

`ifdef FIR_RRC_SCHED_UNDERFLOW_COUNT_EN
  logic [15:0] ufc_r;

  // Saturating underflow counter, updated together with the underflow pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      ufc_r <= 16'h0000;
    end else if (underflow_s && (ufc_r != 16'hFFFF)) begin
      ufc_r <= ufc_r + 16'h0001;
    end else begin
      ufc_r <= ufc_r;
    end
  end

  assign underflow_count = ufc_r;
`else
  assign underflow_count = 16'h0000;
`endif

  assign symbol_ready  = ready_r;
  assign fir_in        = fir_in_r;
  assign fir_in_valid  = fir_in_valid_r;
  assign fir_out_valid = dly_r[FIR_LATENCY-1];
  assign busy          = busy_r;
  assign underflow     = underflow_r;
  assign done          = done_r;

endmodule

// File: tb/tb_fir_rrc_sched.sv
// Testbench for fir_rrc_sched. Two instances: u0 (SPS=4, 21 taps, latency 1)
// and u1 (SPS=1, 21 taps, latency 3). Each is compared every cycle against a
// sample-position reference model, plus directed end-of-test checks.
module tb_fir_rrc_sched;

  localparam int SPS0 = 4;
  localparam int SPS1 = 1;
  localparam int NT   = 21;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]       v, l;
  logic [1:0][11:0] d;
  logic [1:0]       rdy, fiv, fov, bsy, ufl, dn;
  logic [1:0][11:0] fin;
  logic [1:0][15:0] ufc;

  always #5 clk = ~clk;

  fir_rrc_sched #(.SAMPLES_PER_SYMBOL(SPS0), .NUM_TAPS(NT), .FIR_LATENCY(LAT0)) u0 (
    .clk(clk), .rst(rst), .symbol_in(d[0]), .symbol_valid(v[0]), .symbol_last(l[0]),
    .symbol_ready(rdy[0]), .fir_in(fin[0]), .fir_in_valid(fiv[0]),
    .fir_out_valid(fov[0]), .busy(bsy[0]), .underflow(ufl[0]), .done(dn[0]),
    .underflow_count(ufc[0]));

  fir_rrc_sched #(.SAMPLES_PER_SYMBOL(SPS1), .NUM_TAPS(NT), .FIR_LATENCY(LAT1)) u1 (
    .clk(clk), .rst(rst), .symbol_in(d[1]), .symbol_valid(v[1]), .symbol_last(l[1]),
    .symbol_ready(rdy[1]), .fir_in(fin[1]), .fir_in_valid(fiv[1]),
    .fir_out_valid(fov[1]), .busy(bsy[1]), .underflow(ufl[1]), .done(dn[1]),
    .underflow_count(ufc[1]));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: burst described by sample position and symbol count.
  typedef struct {
    int          pos;       // sample index in burst, -1 when idle
    int          nsym;      // symbol slots started so far
    bit          last_seen;
    bit          ready;
    logic [11:0] fin;
    bit          fval;
    bit          uf;
    bit          done;
    int          ufc;
    logic [8:0]  hist;      // hist[k] = fir_in_valid k cycles ago
  } mdl_t;

  mdl_t mdl[2];

  typedef struct packed {
    logic [11:0] d;
    logic        l;
  } sym_t;

  sym_t q0[$];
  sym_t q1[$];
  bit   gaps_en = 1'b0;

  int vcnt[2], dncnt[2], done_at[2], ufcnt[2], first_fin[2];

  task automatic mdl_step(inout mdl_t m, input int sps, input bit r,
                          input bit vv, input bit ll, input logic [11:0] dd);
    bit xfer;
    xfer   = vv && m.ready;
    m.uf   = 1'b0;
    m.done = 1'b0;
    if (r) begin
      m.pos = -1; m.nsym = 0; m.last_seen = 1'b0; m.fin = 12'h000;
      m.ufc = 0; m.ready = 1'b1; m.fval = 1'b0; m.hist = 9'h000;
    end else begin
      m.fin = 12'h000;
      if (m.pos < 0) begin
        if (xfer) begin
          m.pos = 0; m.nsym = 1; m.last_seen = ll; m.fin = dd;
        end
      end else begin
        m.pos++;
        if (m.last_seen && m.pos >= m.nsym * sps + NT - 1) begin
          m.pos = -1;
        end else if ((!m.last_seen || m.pos < m.nsym * sps) && (m.pos % sps == 0)) begin
          m.nsym++;
          if (xfer) begin
            m.fin = dd; m.last_seen = ll;
          end else begin
            m.uf = 1'b1;
            if (m.ufc < 65535) m.ufc++;
          end
        end
        m.done = (m.pos >= 0) && m.last_seen && (m.pos == m.nsym * sps + NT - 2);
      end
      m.fval  = (m.pos >= 0);
      m.ready = (m.pos < 0) || (!m.last_seen && (m.pos % sps == sps - 1));
      m.hist  = {m.hist[7:0], m.fval};
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      vcnt[i] = 0; dncnt[i] = 0; done_at[i] = 0; ufcnt[i] = 0; first_fin[i] = 0;
    end
  endtask

  // One clock: drive inputs, advance model on the edge, compare on negedge.
  task automatic cycle();
    sym_t h;
    bit   have;
    bit   xf;
    mdl_t t;
    int   exp_ufc;
    for (int i = 0; i < 2; i++) begin
      have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (have) begin
        h = (i == 0) ? q0[0] : q1[0];
      end else begin
        h.d = 12'($urandom);
        h.l = 1'($urandom);
      end
      v[i] = have && !(gaps_en && ($urandom_range(0, 4) == 0));
      d[i] = h.d;
      l[i] = h.l;
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      t  = mdl[i];
      xf = v[i] && t.ready && !rst;
      mdl_step(t, (i == 0) ? SPS0 : SPS1, rst, v[i], l[i], d[i]);
      mdl[i] = t;
      if (xf) begin
        if (i == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      t = mdl[i];
`ifdef FIR_RRC_SCHED_UNDERFLOW_COUNT_EN
      exp_ufc = t.ufc;
`else
      exp_ufc = 0;
`endif
      chk($sformatf("u%0d_fir_in", i),       int'(fin[i]), int'(t.fin));
      chk($sformatf("u%0d_fir_in_valid", i), int'(fiv[i]), int'(t.fval));
      chk($sformatf("u%0d_symbol_ready", i), int'(rdy[i]), int'(t.ready));
      chk($sformatf("u%0d_busy", i),         int'(bsy[i]), int'(t.fval));
      chk($sformatf("u%0d_underflow", i),    int'(ufl[i]), int'(t.uf));
      chk($sformatf("u%0d_done", i),         int'(dn[i]),  int'(t.done));
      chk($sformatf("u%0d_fir_out_valid", i), int'(fov[i]),
          int'(t.hist[(i == 0) ? LAT0 : LAT1]));
      chk($sformatf("u%0d_underflow_count", i), int'(ufc[i]), exp_ufc);
      if (fiv[i]) begin
        vcnt[i]++;
        if (vcnt[i] == 1) first_fin[i] = int'(fin[i]);
      end
      if (dn[i]) begin
        dncnt[i]++;
        done_at[i] = vcnt[i];
      end
      if (ufl[i]) ufcnt[i]++;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    rst = 1'b1;
    v = 2'b00; l = 2'b00; d = '0;
    for (int i = 0; i < 2; i++) begin
      mdl[i].pos = -1; mdl[i].nsym = 0; mdl[i].last_seen = 1'b0; mdl[i].ready = 1'b1;
      mdl[i].fin = 12'h000; mdl[i].fval = 1'b0; mdl[i].uf = 1'b0; mdl[i].done = 1'b0;
      mdl[i].ufc = 0; mdl[i].hist = 9'h000;
    end

    // Reset hold with a symbol offered: nothing may transfer.
    q0.push_back(sym_t'{12'h123, 1'b0});
    q1.push_back(sym_t'{12'h321, 1'b0});
    clear_counts();
    run(50);
    chk("t1_ready", int'(rdy[0]), 1);
    chk("t1_fir_in", int'(fin[0]), 0);
    chk("t1_valid_cycles", vcnt[0] + vcnt[1], 0);
    q0.delete();
    q1.delete();
    rst = 1'b0;
    run(2);
    chk("t1_no_xfer", int'(fiv[0]), 0);

    // Single-symbol burst at SPS=4.
    clear_counts();
    q0.push_back(sym_t'{12'h7FF, 1'b1});
    run(30);
    chk("t2_valid_len", vcnt[0], 24);
    chk("t2_done_at", done_at[0], 24);
    chk("t2_done_cnt", dncnt[0], 1);
    chk("t2_first", first_fin[0], 12'h7FF);

    // Back-to-back burst of three symbols.
    clear_counts();
    q0.push_back(sym_t'{12'd100, 1'b0});
    q0.push_back(sym_t'{12'(-100), 1'b0});
    q0.push_back(sym_t'{12'd50, 1'b1});
    run(40);
    chk("t3_valid_len", vcnt[0], 32);
    chk("t3_underflow", ufcnt[0], 0);
    chk("t3_first", first_fin[0], 100);

    // One missing symbol slot mid-burst.
    clear_counts();
    q0.push_back(sym_t'{12'h011, 1'b0});
    q0.push_back(sym_t'{12'h022, 1'b0});
    for (int k = 0; k < 30 && ufcnt[0] == 0; k++) cycle();
    chk("t4_uf_seen", ufcnt[0], 1);
    q0.push_back(sym_t'{12'h033, 1'b1});
    run(40);
    chk("t4_underflow", ufcnt[0], 1);
    chk("t4_valid_len", vcnt[0], 36);
`ifdef FIR_RRC_SCHED_UNDERFLOW_COUNT_EN
    chk("t4_ufc", int'(ufc[0]), 1);
`else
    chk("t4_ufc", int'(ufc[0]), 0);
`endif

    // SPS=1 corner: five consecutive symbols.
    clear_counts();
    for (int k = 1; k <= 5; k++) q1.push_back(sym_t'{12'(k * 17), (k == 5)});
    run(30);
    chk("t5_valid_len", vcnt[1], 25);
    chk("t5_underflow", ufcnt[1], 0);
    chk("t5_done_at", done_at[1], 25);

    // Reset on flush cycle 10 (14th valid cycle).
    clear_counts();
    q0.push_back(sym_t'{12'h155, 1'b1});
    for (int k = 0; k < 40 && vcnt[0] < 14; k++) cycle();
    chk("t6_reach", vcnt[0], 14);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t6_fir_in", int'(fin[0]), 0);
    chk("t6_fov", int'(fov[0]), 0);
    chk("t6_busy", int'(bsy[0]), 0);
    chk("t6_ready", int'(rdy[0]), 1);
    run(15);
    chk("t6_no_done", dncnt[0], 0);

    // Randomized traffic with gaps and occasional resets.
    gaps_en = 1'b1;
    for (int k = 0; k < 2500; k++) begin
      if (q0.size() < 3 && $urandom_range(0, 2) == 0)
        q0.push_back(sym_t'{12'($urandom), ($urandom_range(0, 5) == 0)});
      if (q1.size() < 3 && $urandom_range(0, 2) == 0)
        q1.push_back(sym_t'{12'($urandom), ($urandom_range(0, 5) == 0)});
      rst = ($urandom_range(0, 399) == 0);
      cycle();
    end
    rst = 1'b0;
    gaps_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
